// File: rtl/fc_axil_regbank.sv
// fc_axil_regbank: parametrised AXI4-Lite slave register bank.
//
// Control/status front end for the FC accelerator IPs. Each of NUM_REGS word-sized registers is
// either read/write (stored here) or read-only (RO_MASK bit set, value taken live from reg_in).
// Accesses to indices >= NUM_REGS, and writes to read-only registers, complete with SLVERR and
// have no side effects.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel with byte strobes
//   S_AXI_B*              write response channel
//   S_AXI_AR*             read address channel (ARPROT ignored)
//   S_AXI_R*              read data channel
//   reg_out               flat register view, register i at [i*DW +: DW]
//   reg_in                status values for read-only registers
//   wr_pulse / rd_pulse   one-cycle per-register strobes on successful write / read

module fc_axil_regbank #(
  parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned         NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,

  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,

  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,

  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  output logic [NUM_REGS-1:0]                    rd_pulse
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned StrbW   = DW / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = C_S_AXI_ADDR_WIDTH - AddrLsb;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write FSM states
  localparam logic [2:0] W_IDLE   = 3'd0;
  localparam logic [2:0] W_ADDR   = 3'd1;  // AW accepted, waiting for W
  localparam logic [2:0] W_DATA   = 3'd2;  // W accepted, waiting for AW
  localparam logic [2:0] W_COMMIT = 3'd3;
  localparam logic [2:0] W_RESP   = 3'd4;

  // Read FSM states
  localparam logic R_IDLE  = 1'b0;
  localparam logic R_VALID = 1'b1;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic                ready_en_q;  // holds the READY outputs low until reset has been released
  logic [2:0]          w_state_q, w_state_d;
  logic [IdxW-1:0]     aw_idx_q;
  logic [DW-1:0]       wdata_q;
  logic [StrbW-1:0]    wstrb_q;
  logic [1:0]          bresp_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                r_state_q;
  logic [DW-1:0]       rdata_q;
  logic [1:0]          rresp_q;
  logic [NUM_REGS-1:0] rd_pulse_q;

  logic [DW-1:0]       reg_q    [NUM_REGS];
  logic [DW-1:0]       reg_view [NUM_REGS];

  // ---------------------------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------------------------
  logic aw_hs, w_hs, ar_hs;

  assign S_AXI_AWREADY = ready_en_q && ((w_state_q == W_IDLE) || (w_state_q == W_DATA));
  assign S_AXI_WREADY  = ready_en_q && ((w_state_q == W_IDLE) || (w_state_q == W_ADDR));
  assign S_AXI_ARREADY = ready_en_q && (r_state_q == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // ---------------------------------------------------------------------------------------------
  // Register view: read-only slots show the live status input
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_view[i] = RO_MASK[i] ? reg_in[i*DW +: DW] : reg_q[i];
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DW +: DW] = reg_view[i];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------
  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_sel;
  logic                w_legal;
  logic [DW-1:0]       wmask;

  // An out-of-range index matches no register, so w_sel is empty for every illegal write.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_hit[i] = (aw_idx_q == IdxW'(i));
    end
  end

  assign w_sel   = w_hit & ~RO_MASK;
  assign w_legal = |w_sel;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < StrbW; b++) begin
      wmask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_COMMIT;
        end else if (aw_hs) begin
          w_state_d = W_ADDR;
        end else if (w_hs) begin
          w_state_d = W_DATA;
        end
      end
      W_ADDR:   if (w_hs)  w_state_d = W_COMMIT;
      W_DATA:   if (aw_hs) w_state_d = W_COMMIT;
      W_COMMIT: w_state_d = W_RESP;
      W_RESP:   if (S_AXI_BREADY) w_state_d = W_IDLE;
      default:  w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      if (aw_hs) begin
        aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
      end
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      wr_pulse_q <= '0;
      if (w_state_q == W_COMMIT) begin
        bresp_q    <= w_legal ? RESP_OKAY : RESP_SLVERR;
        wr_pulse_q <= w_sel;
      end
    end
  end

  // Storage for read/write registers; read-only slots are never selected and stay at zero.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
    end else if (w_state_q == W_COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sel[i]) begin
          reg_q[i] <= (reg_q[i] & ~wmask) | (wdata_q & wmask);
        end
      end
    end
  end

  assign S_AXI_BVALID = (w_state_q == W_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign wr_pulse     = wr_pulse_q;

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  logic [IdxW-1:0]     ar_idx;
  logic [NUM_REGS-1:0] r_hit;
  logic [DW-1:0]       r_word;
  logic                r_legal;

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:AddrLsb];

  // r_word stays zero for an out-of-range index, which is the required RDATA on SLVERR.
  always_comb begin
    r_hit  = '0;
    r_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IdxW'(i)) begin
        r_hit[i] = 1'b1;
        r_word   = reg_view[i];
      end
    end
  end

  assign r_legal = |r_hit;

  // Sampling reg_q here (pre-update) gives the old value when a write commits on the same edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q  <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rd_pulse_q <= '0;
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q  <= R_VALID;
            rdata_q    <= r_word;
            rresp_q    <= r_legal ? RESP_OKAY : RESP_SLVERR;
            rd_pulse_q <= r_hit;
          end
        end
        R_VALID: begin
          if (S_AXI_RREADY) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_RVALID = (r_state_q == R_VALID);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign rd_pulse     = rd_pulse_q;

  // Protection bits, byte-offset address bits and status inputs of read/write slots carry no
  // information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[AddrLsb-1:0],
                           S_AXI_ARADDR[AddrLsb-1:0], reg_in};

endmodule

// File: tb/tb_fc_axil_regbank.sv
// Self-checking bench for fc_axil_regbank (32-bit data, 6-bit address, 8 registers, register 7
// read-only). A word-level model of the register file predicts every response.

module tb_fc_axil_regbank;

  localparam int NR = 8;
  localparam logic [7:0] RoMask = 8'h80;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [5:0]    S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [5:0]    S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [255:0]  reg_out;
  logic [255:0]  reg_in;
  logic [7:0]    wr_pulse;
  logic [7:0]    rd_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [NR];
  logic [31:0] d;

  always #5 ACLK = ~ACLK;

  fc_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS          (NR),
    .RO_MASK           (RoMask)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .reg_out      (reg_out),
    .reg_in       (reg_in),
    .wr_pulse     (wr_pulse),
    .rd_pulse     (rd_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected read value of a register index under the model.
  function automatic logic [31:0] exp_rd(input int idx);
    if (idx >= NR) return 32'h0;
    if (RoMask[idx]) return reg_in[idx*32 +: 32];
    return mdl[idx];
  endfunction

  // Wait (bounded) for the selected READY at a negedge, then consume the handshake edge.
  // sel: 0 = AW and W, 1 = AW, 2 = W, 3 = AR
  task automatic wait_hs(input string tag, input int sel);
    logic rdy;
    rdy = 1'b0;
    for (int n = 0; n < 20 && !rdy; n++) begin
      @(negedge ACLK);
      case (sel)
        0:       rdy = S_AXI_AWREADY && S_AXI_WREADY;
        1:       rdy = S_AXI_AWREADY;
        2:       rdy = S_AXI_WREADY;
        default: rdy = S_AXI_ARREADY;
      endcase
    end
    chk(tag, {63'b0, rdy}, 64'd1);
    @(posedge ACLK);
  endtask

  // mode: 0 = AW and W together, 1 = AW first, 2 = W first (gap cycles between them)
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode, input int gap);
    int idx, lat;
    logic legal;
    logic [31:0] mask;
    logic [7:0] exp_pulse;
    idx   = int'(addr[5:2]);
    legal = 1'b0;
    if (idx < NR) legal = !RoMask[idx];
    mask  = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    if (mode == 1) begin
      S_AXI_AWVALID = 1'b1;
      wait_hs("aw_hs", 1);
      #1 S_AXI_AWVALID = 1'b0;
      repeat (gap) @(negedge ACLK);
      chk("aw_hold", {61'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b010);
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b1;
      wait_hs("w_hs", 2);
      #1 S_AXI_WVALID = 1'b0;
    end else if (mode == 2) begin
      S_AXI_WVALID = 1'b1;
      wait_hs("w_hs", 2);
      #1 S_AXI_WVALID = 1'b0;
      repeat (gap) @(negedge ACLK);
      chk("w_hold", {61'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b100);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b1;
      wait_hs("aw_hs", 1);
      #1 S_AXI_AWVALID = 1'b0;
    end else begin
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      wait_hs("aww_hs", 0);
      #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
    end
    @(negedge ACLK);
    lat = 1;
    while (!S_AXI_BVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    chk("wr_lat", 64'(lat), 64'd2);
    if (legal) mdl[idx] = (mdl[idx] & ~mask) | (data & mask);
    exp_pulse = legal ? 8'(1 << idx) : 8'h00;
    chk("bresp", {62'b0, S_AXI_BRESP}, legal ? 64'd0 : 64'd2);
    chk("wr_pulse", {56'b0, wr_pulse}, {56'b0, exp_pulse});
    if (idx < NR) chk("reg_out", {32'b0, reg_out[idx*32 +: 32]}, {32'b0, exp_rd(idx)});
    @(negedge ACLK);
    chk("b_done", {55'b0, S_AXI_BVALID, wr_pulse}, 64'd0);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int idx, lat;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    logic [7:0] exp_p;
    idx = int'(addr[5:2]);
    @(posedge ACLK); #1;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    exp_d = exp_rd(idx);
    exp_r = (idx < NR) ? 2'b00 : 2'b10;
    exp_p = (idx < NR) ? 8'(1 << idx) : 8'h00;
    wait_hs("ar_hs", 3);
    #1 S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    lat = 1;
    while (!S_AXI_RVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    chk("rd_lat", 64'(lat), 64'd1);
    chk("rdata", {32'b0, S_AXI_RDATA}, {32'b0, exp_d});
    chk("rresp", {62'b0, S_AXI_RRESP}, {62'b0, exp_r});
    chk("rd_pulse", {56'b0, rd_pulse}, {56'b0, exp_p});
    data = S_AXI_RDATA;
    @(negedge ACLK);
    chk("r_done", {55'b0, S_AXI_RVALID, rd_pulse}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ARESET        = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < NR; i++) begin
      mdl[i] = 32'h0;
      reg_in[i*32 +: 32] = $urandom;
    end
    reg_in[7*32 +: 32] = 32'hCAFE0001;

    // Reset behaviour
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ready", {61'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("ready_after_rst", {61'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'b111);
    chk("rst_outputs", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA,
                        wr_pulse, rd_pulse}, 64'd0);
    for (int i = 0; i < NR; i++) chk("rst_reg", {32'b0, reg_out[i*32 +: 32]}, {32'b0, exp_rd(i)});

    // Fill and read back every register
    for (int i = 0; i < NR; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < NR; i++) axi_read(6'(i * 4), d);
    chk("ro_read", {32'b0, d}, 64'hCAFE0001);

    // Byte strobes
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(6'h04, 32'h0000_0000, 4'b0101, 0, 0);
    axi_read(6'h04, d);
    chk("strb_read", {32'b0, d}, 64'hFF00FF00);
    axi_write(6'h14, 32'h1234_5678, 4'h0, 0, 0);

    // Split address/data arrival
    axi_write(6'h0C, 32'h0000_1234, 4'hF, 1, 3);
    axi_write(6'h10, 32'h0000_5678, 4'hF, 2, 3);

    // Illegal accesses
    axi_write(6'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(6'h1C, d);
    chk("ro_unchanged", {32'b0, d}, 64'hCAFE0001);
    axi_read(6'h20, d);
    axi_write(6'h24, 32'h1111_1111, 4'hF, 0, 0);

    // Back-pressure with a read and a write hitting register 2 on the same edge
    axi_write(6'h08, 32'h5, 4'hF, 0, 0);
    @(posedge ACLK); #1;
    S_AXI_BREADY  = 1'b0;
    S_AXI_RREADY  = 1'b0;
    S_AXI_AWADDR  = 6'h08;
    S_AXI_WDATA   = 32'h9;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    wait_hs("sim_aww", 0);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARADDR  = 6'h08;
    S_AXI_ARVALID = 1'b1;
    wait_hs("sim_ar", 3);
    #1 S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("sim_rdata", {32'b0, S_AXI_RDATA}, 64'h5);
    chk("sim_resp", {58'b0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP}, 64'b100100);
    chk("sim_reg", {32'b0, reg_out[2*32 +: 32]}, 64'h9);
    chk("sim_pulses", {48'b0, wr_pulse, rd_pulse}, 64'h0404);
    mdl[2] = 32'h9;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("hold", {7'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                   S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse, rd_pulse},
          {7'b0, 3'b000, 2'b11, 2'b00, 2'b00, 32'h5, 16'h0});
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("release", {62'b0, S_AXI_BVALID, S_AXI_RVALID}, 64'd0);
    axi_read(6'h08, d);
    chk("after_write", {32'b0, d}, 64'h9);

    // Reset while the write FSM holds an address
    @(posedge ACLK); #1;
    S_AXI_AWADDR  = 6'h0C;
    S_AXI_AWVALID = 1'b1;
    wait_hs("rst_aw", 1);
    #1 S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("in_waddr", {62'b0, S_AXI_AWREADY, S_AXI_WREADY}, 64'b01);
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_rst", {60'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 64'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("post_rst", {59'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                     S_AXI_RVALID}, 64'b11100);
    for (int i = 0; i < NR; i++) chk("post_rst_reg", {32'b0, reg_out[i*32 +: 32]},
                                     {32'b0, exp_rd(i)});
    @(negedge ACLK);
    chk("no_bresp", {63'b0, S_AXI_BVALID}, 64'd0);
    axi_write(6'h0C, 32'hA5A5_5A5A, 4'hF, 0, 0);
    axi_read(6'h0C, d);
    chk("post_rst_rw", {32'b0, d}, 64'hA5A55A5A);

    // Randomised traffic, including out-of-range and read-only targets
    for (int n = 0; n < 80; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      if (n % 10 == 0) begin
        for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        axi_read(a, d);
      end else begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                  int'($urandom_range(1, 4)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_axil_regbank.md
# fc_axil_regbank

Parametrised AXI4-Lite slave register bank: the control/status front end for the FC accelerator IPs, replacing the fixed four-register slave. It supports configurable register count and data width, byte strobes, read-only status registers fed from the datapath, per-register write/read strobes, and SLVERR for illegal accesses. It sits between the PS AXI interconnect and the FC datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only
- C_S_AXI_ADDR_WIDTH, 6, byte address width; must be ≥ clog2(NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8)
- NUM_REGS, 8, number of registers, 2..64
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in

- ACLK  in  1  clock
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DW/DW/8/1/1  write data channel
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address; ARPROT ignored
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DW/2/1/1  read data
- reg_out  out  NUM_REGS*DW  flat register contents, register i at [i*DW +: DW]; RO slots read as reg_in slice
- reg_in  in  NUM_REGS*DW  status values for RO registers; ignored for RW slots
- wr_pulse  out  NUM_REGS  one-cycle pulse on bit i when register i is successfully written
- rd_pulse  out  NUM_REGS  one-cycle pulse on bit i when register i is successfully read

## Operation
- Index = ADDR[ADDR_WIDTH-1 : clog2(DW/8)]; low byte-offset bits ignored.
- Illegal access: index ≥ NUM_REGS (any access), or write to RO register. Response SLVERR (2'b10), no state change, no pulse; illegal read returns RDATA=0. Legal access: OKAY (2'b00).
- Write FSM: W_IDLE, W_ADDR (AW held, waiting W), W_DATA (W held, waiting AW), W_COMMIT, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. Both handshake same edge → W_COMMIT; AW only → W_ADDR (AWREADY=0); W only → W_DATA (WREADY=0).
  - W_ADDR/W_DATA: wait for missing channel → W_COMMIT.
  - W_COMMIT: byte lanes with WSTRB=1 updated, others kept; wr_pulse asserted; BVALID raised → W_RESP.
  - W_RESP: BVALID, BRESP held stable until BREADY; then → W_IDLE. No AW/W accepted in W_COMMIT/W_RESP.
- Read FSM: R_IDLE (ARREADY=1), R_VALID (ARREADY=0). AR handshake captures data/resp into RDATA/RRESP, raises RVALID, pulses rd_pulse; held until RREADY, then R_IDLE.
- RO register reads return reg_in sampled at the AR handshake edge.
- Read and write channels independent; may run concurrently.

## Timing
- Reset: all RW registers 0; BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse, rd_pulse = 0; AWREADY, WREADY, ARREADY = 0 during reset, 1 from first cycle after ARESET deasserts. Reset mid-transaction aborts it; no response issued.
- Write latency: both handshakes done by edge k → register updated and BVALID=1 after edge k+1; wr_pulse high for cycle k+1..k+2 only. Minimum write throughput 1 per 3 cycles (BREADY held high).
- Read latency: AR handshake at edge k → RVALID=1, RDATA valid after edge k. Throughput 1 per 2 cycles.
- Read and write commit to same register at the same edge: read returns pre-write value.
- WSTRB=0 legal write: OKAY, no bits change, wr_pulse still asserted.
- BVALID/RVALID never drop without BREADY/RREADY; response fields stable while valid.

## Test plan
- Reset then write 0x1,0x2,...,0x8 to addrs 0x00..0x1C (NUM_REGS=8, RO_MASK=0), read back -> RDATA matches, RRESP=OKAY, wr_pulse/rd_pulse one cycle per access on correct bit.
- Write 0xFFFFFFFF to reg 1, then 0x00000000 with WSTRB=4'b0101 -> read 0xFF00FF00.
- AW presented 3 cycles before W, then W 3 cycles before AW -> both commit, BVALID once each, AWREADY/WREADY drop while holding.
- RO_MASK=8'h80, reg_in slot 7=0xCAFE0001: read 0x1C -> 0xCAFE0001 OKAY; write 0x1C -> SLVERR, value unchanged, no wr_pulse; read 0x20 -> SLVERR, RDATA=0.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID/data stable, no new AW/W/AR accepted; simultaneous read+write reg 2 (old 0x5, new 0x9) -> read 0x5, later read 0x9.
- ARESET asserted during W_ADDR -> after release all registers 0, no BVALID, next full write works.
